// File: rtl/add_sub_pkg.sv
// Shared types and constants for the digit-serial adder/subtractor.
package add_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/digit_adder.sv
// DIGIT-bit ripple-carry adder; also exposes the carry into its MSB for overflow detection.
module digit_adder #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             ci,
    output logic [DIGIT-1:0] sum,
    output logic             co,
    output logic             cm
);

    logic [DIGIT:0] c_s;

    // Ripple the carry through each bit position.
    always_comb begin
        c_s    = '0;
        sum    = '0;
        c_s[0] = ci;
        for (int i = 0; i < DIGIT; i++) begin
            sum[i]   = x[i] ^ y[i] ^ c_s[i];
            c_s[i+1] = (x[i] & y[i]) | (c_s[i] & (x[i] ^ y[i]));
        end
    end

    assign co = c_s[DIGIT];
    assign cm = c_s[DIGIT-1];

endmodule

// File: rtl/add_sub_serial.sv
// Digit-serial two's-complement adder/subtractor, LSB digit first, start/done handshake.
// Define ADD_SUB_SAT_EN to clamp s to the signed limits on overflow (default: wrap).
module add_sub_serial
    import add_sub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int              N    = WIDTH / DIGIT;
    localparam int              CW   = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0]   LAST = CW'(N - 1);
    localparam logic [WIDTH-1:0] SMIN = WIDTH'(1'b1) << (WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             mode_q, mode_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [DIGIT-1:0] dsum_s;
    logic             dco_s;
    logic             dcm_s;
    logic [WIDTH-1:0] acc_next_s;
    logic             ovf_raw_s;
    logic [WIDTH-1:0] res_s;

    digit_adder #(.DIGIT(DIGIT)) u_digit_adder (
        .x   (a_q[DIGIT-1:0]),
        .y   (b_q[DIGIT-1:0]),
        .ci  (carry_q),
        .sum (dsum_s),
        .co  (dco_s),
        .cm  (dcm_s)
    );

    // Result digits enter from the MSB end, so after N shifts digit 0 sits at the LSB.
    always_comb begin
        acc_next_s = (acc_q >> DIGIT) | (WIDTH'(dsum_s) << (WIDTH - DIGIT));
        ovf_raw_s  = dcm_s ^ dco_s;
    end

    // Final result value; on the last digit a_q[DIGIT-1] is the sign bit of A.
    always_comb begin
        res_s = acc_next_s;
`ifdef ADD_SUB_SAT_EN
        if (ovf_raw_s) begin
            res_s = a_q[DIGIT-1] ? SMIN : ~SMIN;
        end else begin
            res_s = acc_next_s;
        end
`endif
    end

    // Next-state and datapath control.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        carry_d = carry_q;
        s_d     = s_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b ^ {WIDTH{mode}};
                    mode_d  = mode;
                    carry_d = mode;
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                acc_d   = acc_next_s;
                carry_d = dco_s;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    // Outputs load on the edge that enters DONE so they are valid with done.
                    s_d     = res_s;
                    cout_d  = (mode_q == MODE_SUB) ? ~dco_s : dco_s;
                    ovf_d   = ovf_raw_s;
                    zero_d  = (res_s == '0);
                    state_d = DONE;
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            carry_q <= 1'b0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            carry_q <= carry_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign s    = s_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
    assign zero = zero_q;

endmodule

// File: tb/tb_add_sub_serial.sv
// Self-checking bench for add_sub_serial (WIDTH=16, DIGIT=4): directed vectors plus an arithmetic model.
module tb_add_sub_serial;

    logic        clk;
    logic        rst;
    logic        start;
    logic        mode;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] s;
    logic        cout;
    logic        ovf;
    logic        zero;

`ifdef ADD_SUB_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    add_sub_serial #(.WIDTH(16), .DIGIT(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .mode  (mode),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .cout  (cout),
        .ovf   (ovf),
        .zero  (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        m;
    } op_t;

    typedef struct packed {
        logic [15:0] s;
        logic        c;
        logic        o;
        logic        z;
    } res_t;

    op_t  exp_q[$];
    res_t held;
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Integer-arithmetic reference for one operation.
    function automatic res_t model(input op_t op);
        res_t r;
        int   sa, sb, ua, ub, rs;
        sa = int'($signed(op.a));
        sb = int'($signed(op.b));
        ua = int'(op.a);
        ub = int'(op.b);
        rs = op.m ? (sa - sb) : (sa + sb);
        r.o = (rs > 32767) || (rs < -32768);
        r.c = op.m ? (ua < ub) : ((ua + ub) > 65535);
        r.s = rs[15:0];
        if (SAT && rs > 32767)  r.s = 16'h7FFF;
        if (SAT && rs < -32768) r.s = 16'h8000;
        r.z = (r.s == 16'h0000);
        return r;
    endfunction

    // Per-cycle compare against the model and held values.
    always @(negedge clk) begin
        res_t e;
        chk("busy_done_excl", {31'd0, busy & done}, 32'd0);
        if (rst) begin
            held = '0;
            chk("rst_busy", {31'd0, busy}, 32'd0);
            chk("rst_done", {31'd0, done}, 32'd0);
            chk("rst_s", {16'd0, s}, 32'd0);
        end else if (done) begin
            if (exp_q.size() == 0) begin
                chk("spurious_done", {31'd0, done}, 32'd0);
            end else begin
                e = model(exp_q.pop_front());
                chk("model_s", {16'd0, s}, {16'd0, e.s});
                chk("model_cout", {31'd0, cout}, {31'd0, e.c});
                chk("model_ovf", {31'd0, ovf}, {31'd0, e.o});
                chk("model_zero", {31'd0, zero}, {31'd0, e.z});
                held = e;
            end
        end else begin
            chk("hold_s", {16'd0, s}, {16'd0, held.s});
            chk("hold_flags", {29'd0, cout, ovf, zero}, {29'd0, held.c, held.o, held.z});
        end
    end

    task automatic do_op(input logic [15:0] ia, input logic [15:0] ib, input logic im,
                         input logic [15:0] es, input logic ec, input logic eo,
                         input logic ez, input bit poke);
        int lat;
        int bc;
        start = 1'b1;
        a     = ia;
        b     = ib;
        mode  = im;
        exp_q.push_back('{a: ia, b: ib, m: im});
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = 1;
        bc    = 0;
        while (!done && lat < 20) begin
            if (busy) bc++;
            if (poke && lat == 2) begin
                start = 1'b1;
                a     = 16'h1111;
                b     = 16'h1111;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        start = 1'b0;
        chk("done_seen", {31'd0, done}, 32'd1);
        chk("latency", lat, 32'd5);
        chk("busy_cycles", bc, 32'd4);
        chk("lit_s", {16'd0, s}, {16'd0, es});
        chk("lit_flags", {29'd0, cout, ovf, zero}, {29'd0, ec, eo, ez});
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        mode  = 1'b0;
        a     = 16'h0000;
        b     = 16'h0000;
        held  = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_outputs", {12'd0, s, busy, done, cout, ovf, zero}, 32'd0);
        @(posedge clk);
        #1;

        do_op(16'h1234, 16'h0001, 1'b0, 16'h1235, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        do_op(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b1, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        do_op(16'h7FFF, 16'h0001, 1'b0, SAT ? 16'h7FFF : 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
        do_op(16'h8000, 16'h0001, 1'b1, SAT ? 16'h8000 : 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
        do_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
        do_op(16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        do_op(16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1);
        @(posedge clk); #1;
        do_op(16'h8000, 16'h8000, 1'b0, SAT ? 16'h8000 : 16'h0000, 1'b1, 1'b1, SAT ? 1'b0 : 1'b1, 1'b0);
        @(posedge clk); #1;
        do_op(16'h4321, 16'h0ABC, 1'b0, 16'h4DDD, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;

        // Mid-operation reset with an ignored start pulse in RUN.
        start = 1'b1;
        a     = 16'h1000;
        b     = 16'h0234;
        mode  = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        a     = 16'h1111;
        b     = 16'h1111;
        @(posedge clk); #1;
        start = 1'b0;
        rst   = 1'b1;
        exp_q.delete();
        #1;
        chk("midop_reset", {12'd0, s, busy, done, cout, ovf, zero}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("no_done_after_reset", {12'd0, s, busy, done, cout, ovf, zero}, 32'd0);
        do_op(16'h00FF, 16'h0100, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
